// File: rtl/jk_excitation_driver.sv
// Steers a bank of JK flip-flops to a requested value with registered J/K
// excitations, then verifies the Q feedback and retries a bounded number of times.
module jk_excitation_driver #(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] target,
  input  logic             target_valid,
  output logic             target_ready,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic             clear_err,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] change_count,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_tgt;
  logic [WIDTH-1:0] r_q0;
  logic [3:0]       r_retry;
  logic [WIDTH-1:0] r_j;
  logic [WIDTH-1:0] r_k;
  logic             r_done;
  logic             r_error;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_match;
  logic             w_retry_ok;
  logic [WIDTH-1:0] w_tgt_sel;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [CNT_W-1:0] w_delta_pop;

  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      acc = acc + CNT_W'(d[i]);
    end
    return acc;
  endfunction

  // Handshake: a target transfers on a rising edge where target_valid and
  // target_ready are both high; target_ready is high only in IDLE and nothing
  // on target/target_valid is looked at in any other state.
  always_comb begin
    w_accept    = target_valid && (r_state == S_IDLE);
    w_match     = (q == r_tgt);
    w_retry_ok  = (r_retry != MAX_R);
    w_tgt_sel   = (r_state == S_IDLE) ? target : r_tgt;
    // Set-only / reset-only excitation; toggle (J=K=1) can never be formed.
    w_j         = ~q & w_tgt_sel;
    w_k         = q & ~w_tgt_sel;
    w_delta_pop = popcount(r_tgt ^ r_q0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      r_q0    <= '0;
      r_retry <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      r_j    <= '0;
      r_k    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_tgt   <= target;
            r_q0    <= q;
            r_retry <= '0;
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_match) begin
            r_done  <= 1'b1;
            r_count <= r_count + w_delta_pop;
            r_state <= S_IDLE;
          end else if (w_retry_ok) begin
            r_retry <= r_retry + 4'd1;
            r_j     <= w_j;
            r_k     <= w_k;
            r_state <= S_DRIVE;
          end else begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_ERROR: begin
          if (clear_err) begin
            r_error <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign target_ready = (r_state == S_IDLE);
  assign J            = r_j;
  assign K            = r_k;
  assign done         = r_done;
  assign error        = r_error;
  assign change_count = r_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench: a behavioural JK bank closes the loop, a scoreboard queue
// holds the expected done/error outcome of each target, a monitor pops it.
module tb_jk_excitation_driver;

  localparam int WIDTH     = 4;
  localparam int MAX_RETRY = 2;
  localparam int CNT_W     = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             target_ready;
  logic [WIDTH-1:0] bank_q;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             clear_err;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] change_count;
  logic [1:0]       dbg_state;

  logic             bank_set;
  logic [WIDTH-1:0] bank_val;
  logic [WIDTH-1:0] stuck;

  // MSB = outcome is error, low bits = change_count expected at that outcome.
  logic [CNT_W:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic prev_err = 1'b0;

  jk_excitation_driver #(
    .WIDTH(WIDTH), .MAX_RETRY(MAX_RETRY), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .target(target), .target_valid(target_valid),
    .target_ready(target_ready), .q(bank_q), .J(J), .K(K), .clear_err(clear_err),
    .done(done), .error(error), .change_count(change_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural JK bank: Q+ = J&~Q | ~K&Q, with optional stuck-at-0 bits.
  always @(posedge clk) begin
    if (bank_set) bank_q <= bank_val;
    else          bank_q <= ((bank_q & ~K) | (~bank_q & J)) & ~stuck;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      chk("jk_no_toggle", 32'(J & K), 32'd0);
      chk("done_error_exclusive", 32'(done & error), 32'd0);
      if (done || (error && !prev_err)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got done=%0b error=%0b expected no outcome at %0t",
                   done, error, $time);
        end else begin
          logic [CNT_W:0] e;
          e = exp_q.pop_front();
          chk("sb_outcome_is_error", 32'(error), 32'(e[CNT_W]));
          chk("sb_change_count", 32'(change_count), 32'(e[CNT_W-1:0]));
        end
      end
    end
    prev_err <= error;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic preset_bank(input logic [WIDTH-1:0] v);
    bank_set = 1'b1;
    bank_val = v;
    @(posedge clk); #1;
    bank_set = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] ej,
                      input logic [WIDTH-1:0] ek, input logic is_err,
                      input logic [CNT_W-1:0] ecnt, input logic hold);
    int cyc;
    int drives;
    cyc = 0;
    while (!target_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("ready_before_send", 32'(target_ready), 32'd1);
    target       = tgt;
    target_valid = 1'b1;
    exp_q.push_back({is_err, ecnt});
    @(posedge clk); #1;
    if (!hold) target_valid = 1'b0;
    chk("drive_state", 32'(dbg_state), 32'(S_DRIVE));
    chk("drive_j", 32'(J), 32'(ej));
    chk("drive_k", 32'(K), 32'(ek));
    if (!is_err) begin
      @(posedge clk); #1;
      chk("check_state", 32'(dbg_state), 32'(S_CHECK));
      chk("check_j_zero", 32'(J), 32'd0);
      chk("check_k_zero", 32'(K), 32'd0);
      chk("ready_busy", 32'(target_ready), 32'd0);
      @(posedge clk); #1;
      chk("done_latency", 32'(done), 32'd1);
      target_valid = 1'b0;
      @(posedge clk); #1;
      chk("done_pulse_width", 32'(done), 32'd0);
    end else begin
      drives = 1;
      cyc    = 0;
      while (!error && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
        if (dbg_state == S_DRIVE && J == ej) drives++;
      end
      chk("error_cycle", 32'(cyc), 32'd6);
      chk("drive_attempts", 32'(drives), 32'd3);
      chk("ready_in_error", 32'(target_ready), 32'd0);
    end
  endtask

  initial begin
    logic [CNT_W-1:0] m;
    logic [WIDTH-1:0] t;
    reset_n      = 1'b0;
    target       = '0;
    target_valid = 1'b0;
    clear_err    = 1'b0;
    bank_set     = 1'b1;
    bank_val     = '0;
    stuck        = '0;
    repeat (3) @(posedge clk);
    #1;
    target_valid = 1'b1;
    chk("rst_j", 32'(J), 32'd0);
    chk("rst_k", 32'(K), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(change_count), 32'd0);
    chk("rst_ready", 32'(target_ready), 32'd1);
    @(posedge clk); #1;
    chk("rst_holds_idle", 32'(dbg_state), 32'(S_IDLE));
    target_valid = 1'b0;
    bank_set     = 1'b0;
    reset_n      = 1'b1;
    @(posedge clk); #1;

    send(4'b1010, 4'b1010, 4'b0000, 1'b0, 6'd2, 1'b0);
    chk("bank_after_first", 32'(bank_q), 32'b1010);
    send(4'b0110, 4'b0100, 4'b1000, 1'b0, 6'd4, 1'b0);
    chk("bank_after_second", 32'(bank_q), 32'b0110);
    send(4'b0110, 4'b0000, 4'b0000, 1'b0, 6'd4, 1'b1);

    preset_bank(4'b0000);
    stuck = 4'b0001;
    send(4'b0001, 4'b0001, 4'b0000, 1'b1, 6'd4, 1'b0);
    @(posedge clk); #1;
    chk("error_sticky", 32'(error), 32'd1);
    chk("error_state", 32'(dbg_state), 32'(S_ERROR));
    chk("error_ready_low", 32'(target_ready), 32'd0);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("clear_error", 32'(error), 32'd0);
    chk("clear_to_idle", 32'(dbg_state), 32'(S_IDLE));
    chk("count_kept_on_error", 32'(change_count), 32'd4);
    stuck = '0;

    m = 6'd4;
    for (int i = 0; i < 15; i++) begin
      t = (i % 2 == 0) ? 4'b1111 : 4'b0000;
      m = m + 6'd4;
      send(t, t, ~t, 1'b0, m, 1'b0);
    end
    chk("wrap_to_zero", 32'(change_count), 32'd0);
    send(4'b1110, 4'b0000, 4'b0001, 1'b0, 6'd1, 1'b0);
    chk("wrap_low", 32'(change_count), 32'd1);

    target       = 4'b0001;
    target_valid = 1'b1;
    @(posedge clk); #1;
    target_valid = 1'b0;
    chk("abort_drive_j", 32'(J), 32'b0001);
    chk("abort_drive_k", 32'(K), 32'b1110);
    reset_n = 1'b0;
    #1;
    chk("abort_j", 32'(J), 32'd0);
    chk("abort_k", 32'(K), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_count", 32'(change_count), 32'd0);
    chk("abort_ready", 32'(target_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("abort_bank_unchanged", 32'(bank_q), 32'b1110);
    send(4'b1100, 4'b0000, 4'b0010, 1'b0, 6'd1, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
